// File: rtl/block_data_memory.sv
// rtl/block_data_memory.sv - block-read / word-write data memory with fixed latency
// Runs a self-initialising sweep after every reset, then serves one request at a time.
module block_data_memory #(
  parameter int WORD_LEN    = 32,
  parameter int ADDRESS_LEN = 32,
  parameter int MEM_CAP     = 16384,
  parameter int BLOCK_WORDS = 4,
  parameter int LATENCY     = 4,
  parameter int INIT_LO     = 1024,
  parameter int INIT_HI     = 9216
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_write,
  input  logic [ADDRESS_LEN-1:0]          req_addr,
  input  logic [WORD_LEN-1:0]             req_wdata,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic                            resp_write,
  output logic                            resp_err,
  output logic [ADDRESS_LEN-1:0]          resp_addr,
  output logic [BLOCK_WORDS*WORD_LEN-1:0] resp_rdata,
  output logic                            init_done
);

  localparam int IDX_W = (MEM_CAP > 1) ? $clog2(MEM_CAP) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [ADDRESS_LEN:0]   CAP_EXT  = (ADDRESS_LEN + 1)'(MEM_CAP);
  localparam logic [ADDRESS_LEN-1:0] OFF_MASK = ADDRESS_LEN'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                          r_state;
  state_t                          w_next_state;
  logic [WORD_LEN-1:0]             r_mem [MEM_CAP];
  logic [IDX_W-1:0]                r_ptr;
  logic [CNT_W-1:0]                r_cnt;
  logic                            r_init_done;
  logic                            r_write;
  logic [ADDRESS_LEN-1:0]          r_addr;
  logic [WORD_LEN-1:0]             r_wdata;
  logic                            r_resp_valid;
  logic                            r_resp_write;
  logic                            r_resp_err;
  logic [ADDRESS_LEN-1:0]          r_resp_addr;
  logic [BLOCK_WORDS*WORD_LEN-1:0] r_resp_rdata;

  logic                            w_accept;
  logic                            w_enter_resp;
  logic                            w_cur_write;
  logic [ADDRESS_LEN-1:0]          w_cur_addr;
  logic [WORD_LEN-1:0]             w_cur_wdata;
  logic [ADDRESS_LEN-1:0]          w_base_addr;
  logic [IDX_W-1:0]                w_idx;
  logic [IDX_W-1:0]                w_base_idx;
  logic [IDX_W-1:0]                w_word_idx;
  logic                            w_err;
  logic [WORD_LEN-1:0]             w_init_word;
  logic [BLOCK_WORDS*WORD_LEN-1:0] w_block;

  assign w_accept = (r_state == S_IDLE) && req_valid;

  // With LATENCY=1 the response is built on the acceptance edge, before the capture registers load.
  assign w_cur_write = (r_state == S_IDLE) ? req_write : r_write;
  assign w_cur_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_cur_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;

  assign w_base_addr = w_cur_addr & ~OFF_MASK;
  assign w_idx       = w_cur_addr[IDX_W-1:0];
  assign w_base_idx  = w_base_addr[IDX_W-1:0];
  assign w_err       = ({1'b0, w_cur_addr} >= CAP_EXT);

  assign w_init_word = ((32'(r_ptr) >= INIT_LO) && (32'(r_ptr) < INIT_HI)) ? WORD_LEN'(r_ptr) : '0;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_INIT: if (r_ptr == IDX_W'(MEM_CAP - 1)) w_next_state = S_IDLE;
      S_IDLE: if (req_valid) w_next_state = (LATENCY == 1) ? S_RESP : S_WAIT;
      S_WAIT: if (r_cnt == CNT_W'(1)) w_next_state = S_RESP;
      S_RESP: if (resp_ready) w_next_state = S_IDLE;
      default: w_next_state = S_INIT;
    endcase
  end

  assign w_enter_resp = (r_state != S_RESP) && (w_next_state == S_RESP);

  // Merge the pending write into the returned block so the response shows the new value.
  always_comb begin
    w_block    = '0;
    w_word_idx = w_base_idx;
    for (int k = 0; k < BLOCK_WORDS; k++) begin
      w_word_idx = w_base_idx + IDX_W'(k);
      if (w_cur_write && (w_word_idx == w_idx))
        w_block[k*WORD_LEN +: WORD_LEN] = w_cur_wdata;
      else
        w_block[k*WORD_LEN +: WORD_LEN] = r_mem[w_word_idx];
    end
    if (w_err) w_block = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_INIT;
    else      r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_init_done  <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_write <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_addr  <= '0;
      r_resp_rdata <= '0;
    end else begin
      if (r_state == S_INIT) begin
        r_ptr <= r_ptr + IDX_W'(1);
        if (w_next_state == S_IDLE) r_init_done <= 1'b1;
      end
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_cnt   <= CNT_W'(LATENCY - 1);
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_enter_resp) begin
        r_resp_valid <= 1'b1;
        r_resp_write <= w_cur_write;
        r_resp_err   <= w_err;
        r_resp_addr  <= w_base_addr;
        r_resp_rdata <= w_block;
      end else if ((r_state == S_RESP) && resp_ready) begin
        r_resp_valid <= 1'b0;
      end
    end
  end

  // Reset forces S_INIT, so an in-flight write can never land here.
  always_ff @(posedge clk) begin
    if (r_state == S_INIT)
      r_mem[r_ptr] <= w_init_word;
    else if (w_enter_resp && w_cur_write && !w_err)
      r_mem[w_idx] <= w_cur_wdata;
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_write = r_resp_write;
  assign resp_err   = r_resp_err;
  assign resp_addr  = r_resp_addr;
  assign resp_rdata = r_resp_rdata;
  assign init_done  = r_init_done;

endmodule

// File: tb/tb_block_data_memory.sv
// tb/tb_block_data_memory.sv - scoreboard bench for block_data_memory
// Main instance uses LATENCY=3; a small LATENCY=1 instance covers the single-edge path.
module tb_block_data_memory;

  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b1;
  logic [31:0]  req_addr = '0, req_wdata = '0;
  logic         req_ready, resp_valid, resp_write, resp_err, init_done;
  logic [31:0]  resp_addr;
  logic [127:0] resp_rdata;

  logic         req1_valid = 1'b0, req1_write = 1'b0, resp1_ready = 1'b1;
  logic [31:0]  req1_addr = '0, req1_wdata = '0;
  logic         req1_ready, resp1_valid, resp1_write, resp1_err, init1_done;
  logic [31:0]  resp1_addr;
  logic [63:0]  resp1_rdata;

  always #5 clk = ~clk;

  block_data_memory #(.WORD_LEN(32), .ADDRESS_LEN(32), .MEM_CAP(64), .BLOCK_WORDS(4),
                      .LATENCY(LAT), .INIT_LO(16), .INIT_HI(48)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
    .resp_err(resp_err), .resp_addr(resp_addr), .resp_rdata(resp_rdata),
    .init_done(init_done));

  block_data_memory #(.WORD_LEN(32), .ADDRESS_LEN(32), .MEM_CAP(8), .BLOCK_WORDS(2),
                      .LATENCY(1), .INIT_LO(2), .INIT_HI(6)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req1_valid), .req_ready(req1_ready),
    .req_write(req1_write), .req_addr(req1_addr), .req_wdata(req1_wdata),
    .resp_valid(resp1_valid), .resp_ready(resp1_ready), .resp_write(resp1_write),
    .resp_err(resp1_err), .resp_addr(resp1_addr), .resp_rdata(resp1_rdata),
    .init_done(init1_done));

  typedef struct {
    logic         wr;
    logic         err;
    logic [31:0]  addr;
    logic [127:0] data;
    int           hs;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0, errors = 0;
  int          cyc = 0;
  int          rise_cyc = 0;
  logic        prev_valid = 1'b0;
  logic [31:0] model [64];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] blk4(input logic [31:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  function automatic logic [127:0] model_blk(input int a);
    int b;
    b = a & ~3;
    return {model[b+3], model[b+2], model[b+1], model[b]};
  endfunction

  task automatic model_init();
    for (int p = 0; p < 64; p++) model[p] = (p >= 16 && p < 48) ? 32'(p) : 32'd0;
  endtask

  // Monitor: pops one expectation per response handshake.
  always @(negedge clk) begin
    if (resp_valid && !prev_valid) rise_cyc = cyc;
    if (resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp actual=%h required=none", resp_addr);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_write", 128'(resp_write), 128'(mon_e.wr));
        chk("resp_err", 128'(resp_err), 128'(mon_e.err));
        chk("resp_addr", 128'(resp_addr), 128'(mon_e.addr));
        chk("resp_rdata", resp_rdata, mon_e.data);
        chk("latency", 128'(rise_cyc - mon_e.hs), 128'(LAT));
      end
    end
    prev_valid = resp_valid;
  end

  task automatic issue(input logic wr, input int a, input logic [31:0] d, input logic e_err,
                       input logic [31:0] e_addr, input logic [127:0] e_data, input bit push);
    int   n;
    exp_t x;
    n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_addr = 32'(a); req_wdata = d;
    @(negedge clk);
    while (!req_ready && n < 300) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=0 required=1");
    end else if (push) begin
      x.wr = wr; x.err = e_err; x.addr = e_addr; x.data = e_data; x.hs = cyc;
      sb.push_back(x);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_req_ready"}, 128'(req_ready), 128'(0));
    chk({tag, "_resp_valid"}, 128'(resp_valid), 128'(0));
    chk({tag, "_resp_write"}, 128'(resp_write), 128'(0));
    chk({tag, "_resp_err"}, 128'(resp_err), 128'(0));
    chk({tag, "_init_done"}, 128'(init_done), 128'(0));
    chk({tag, "_resp_addr"}, 128'(resp_addr), 128'(0));
    chk({tag, "_resp_rdata"}, resp_rdata, 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, start;
    model_init();
    #2 rst = 1'b0;
    @(negedge clk);
    chk_zero_outputs("reset");

    // Init sweep with a read held pending: ready only after exactly 64 edges.
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd18;
    start = cyc; n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      chk("init_done_early", 128'(init_done), 128'(0));
      @(negedge clk); n++;
    end
    chk("init_cycles", 128'(cyc - start), 128'(64));
    chk("init_done", 128'(init_done), 128'(1));
    sb.push_back('{wr: 1'b0, err: 1'b0, addr: 32'd16, data: blk4(16, 17, 18, 19), hs: cyc});
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain();

    issue(1'b0, 4, 32'd0, 1'b0, 32'd4, 128'd0, 1'b1); drain();
    issue(1'b1, 21, 32'hDEADBEEF, 1'b0, 32'd20, blk4(20, 32'hDEADBEEF, 22, 23), 1'b1); drain();
    model[21] = 32'hDEADBEEF;
    issue(1'b0, 23, 32'd0, 1'b0, 32'd20, blk4(20, 32'hDEADBEEF, 22, 23), 1'b1); drain();
    issue(1'b0, 70, 32'd0, 1'b1, 32'd68, 128'd0, 1'b1); drain();
    issue(1'b1, 64, 32'h55AA55AA, 1'b1, 32'd64, 128'd0, 1'b1); drain();
    for (int b = 0; b < 16; b++) begin
      issue(1'b0, b * 4, 32'd0, 1'b0, 32'(b * 4), model_blk(b * 4), 1'b1);
      drain();
    end

    // Back-pressure: response must hold for five stalled cycles.
    resp_ready = 1'b0;
    issue(1'b0, 41, 32'd0, 1'b0, 32'd40, blk4(40, 41, 42, 43), 1'b1);
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 128'(resp_valid), 128'(1));
      chk("stall_addr", 128'(resp_addr), 128'(40));
      chk("stall_rdata", resp_rdata, blk4(40, 41, 42, 43));
      chk("stall_req_ready", 128'(req_ready), 128'(0));
      @(negedge clk);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_hs_req_ready", 128'(req_ready), 128'(1));
    chk("post_hs_resp_valid", 128'(resp_valid), 128'(0));
    drain();

    // Reset mid-WAIT of a write: write dropped, sweep rerun.
    issue(1'b1, 30, 32'h12345678, 1'b0, 32'd28, 128'd0, 1'b0);
    #3 rst = 1'b0;
    #1 chk_zero_outputs("async_rst");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    model_init();
    n = 0;
    @(negedge clk);
    while (!init_done && n < 200) begin @(negedge clk); n++; end
    chk("reinit_done", 128'(init_done), 128'(1));
    issue(1'b0, 30, 32'd0, 1'b0, 32'd28, blk4(28, 29, 30, 31), 1'b1); drain();
    issue(1'b0, 21, 32'd0, 1'b0, 32'd20, blk4(20, 21, 22, 23), 1'b1); drain();

    // LATENCY=1 instance: response visible right after the acceptance edge.
    chk("lat1_init_done", 128'(init1_done), 128'(1));
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_addr = 32'd3;
    @(negedge clk);
    chk("lat1_req_ready", 128'(req1_ready), 128'(1));
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("lat1_resp_valid", 128'(resp1_valid), 128'(1));
    chk("lat1_resp_addr", 128'(resp1_addr), 128'(2));
    chk("lat1_resp_rdata", 128'(resp1_rdata), 128'(64'h00000003_00000002));
    chk("lat1_resp_err", 128'(resp1_err), 128'(0));
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
